// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for a 4-bit up/down program counter: latches the ROM word,
// decodes jump/branch/step-back/halt opcodes and drives the counter's control pins.
module pc_sequencer #(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] pc_q,
    input  logic       pc_tc,
    input  logic [7:0] instr,
    input  logic       zero_flag,
    input  logic       start,
    output logic       pc_reset_n,
    output logic       pc_load_n,
    output logic [3:0] pc_load_value,
    output logic       pc_hold,
    output logic       pc_up,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_BACK = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       fault_q, fault_d;

    logic       do_load;
    logic       count_up;
    logic       wrap_hit;

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        fault_d       = fault_q;
        pc_reset_n    = 1'b1;
        pc_load_n     = 1'b1;
        pc_load_value = 4'd0;
        pc_hold       = 1'b1;
        pc_up         = 1'b1;
        do_load       = 1'b0;
        count_up      = 1'b1;
        wrap_hit      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                pc_reset_n = 1'b0;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (ir_q[7:4])
                    OP_JMP:  do_load = 1'b1;
                    OP_JZ:   do_load = zero_flag;
                    OP_JNZ:  do_load = ~zero_flag;
                    OP_BACK: count_up = 1'b0;
                    default: count_up = 1'b1;
                endcase

                // Loads never fault; only a count that would cross 15<->0 is trapped.
                wrap_hit = !WRAP_EN && !do_load &&
                           (count_up ? pc_tc : (pc_q == 4'd0));

                if (do_load) begin
                    pc_load_n     = 1'b0;
                    pc_load_value = ir_q[3:0];
                end else if (!wrap_hit) begin
                    pc_hold = 1'b0;
                    pc_up   = count_up;
                end

                if (wrap_hit) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else if (ir_q[7:4] == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start && !fault_q) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        // Reset overrides the counter controls at once so an in-flight load becomes a clear.
        if (reset) begin
            pc_reset_n    = 1'b0;
            pc_load_n     = 1'b1;
            pc_load_value = 4'd0;
            pc_hold       = 1'b1;
            pc_up         = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ir_q    <= 8'h00;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
        end
    end

    assign ir       = reset ? 8'h00 : ir_q;
    assign ir_valid = (state_q == ST_EXEC) && !reset;
    assign halted   = (state_q == ST_HALT) && !reset;
    assign fault    = fault_q && !reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: two sequencers (wrap enabled / disabled) each drive a behavioural
// 4-bit counter over a shared ROM; an ISA-level model predicts every executed instruction.
module tb_pc_sequencer;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] ir;
        logic       load_n;
        logic [3:0] load_val;
        logic       hold;
        logic       up;
        logic       halt_after;
        logic       fault_after;
    } rec_t;

    logic clock = 1'b0;
    logic reset;

    logic [1:0][3:0] cnt;
    logic [1:0]      tc;
    logic [1:0][7:0] instr;
    logic [1:0]      zf;
    logic [1:0]      start;

    logic [1:0]      pc_reset_n, pc_load_n, pc_hold, pc_up, ir_valid, halted, fault;
    logic [1:0][3:0] pc_load_value;
    logic [1:0][7:0] ir;

    logic [7:0] rom [16];

    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;

    int   m_pc    [2];
    bit   m_halt  [2];
    bit   m_fault [2];
    rec_t q0 [$];
    rec_t q1 [$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pc_sequencer #(.WRAP_EN(g == 0 ? 1'b1 : 1'b0)) u_dut (
            .clock         (clock),
            .reset         (reset),
            .pc_q          (cnt[g]),
            .pc_tc         (tc[g]),
            .instr         (instr[g]),
            .zero_flag     (zf[g]),
            .start         (start[g]),
            .pc_reset_n    (pc_reset_n[g]),
            .pc_load_n     (pc_load_n[g]),
            .pc_load_value (pc_load_value[g]),
            .pc_hold       (pc_hold[g]),
            .pc_up         (pc_up[g]),
            .ir            (ir[g]),
            .ir_valid      (ir_valid[g]),
            .halted        (halted[g]),
            .fault         (fault[g])
        );
    end

    // Program counter and ROM environment.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!pc_reset_n[i])      cnt[i] <= 4'd0;
            else if (!pc_load_n[i])  cnt[i] <= pc_load_value[i];
            else if (!pc_hold[i])    cnt[i] <= pc_up[i] ? cnt[i] + 4'd1 : cnt[i] - 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            instr[i] = rom[cnt[i]];
            tc[i]    = (cnt[i] == 4'hF);
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: actual=%0h required=%0h", name, d, act, exp);
        end
    endtask

    function automatic void push_rec(input int d, input rec_t r);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic rec_t pop_rec(input int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // ISA-level reference: dut0 wraps modulo 16, dut1 traps any count leaving 0..15.
    function automatic void model_step(input int d, input logic [7:0] ins, input logic z, output rec_t r);
        int op;
        int nxt;
        int delta;
        bit taken;
        op    = ins[7:4];
        taken = (op == 10) || (op == 11 && z) || (op == 12 && !z);
        delta = (op == 9) ? -1 : 1;
        r.pc       = m_pc[d][3:0];
        r.ir       = ins;
        r.load_n   = 1'b1;
        r.load_val = 4'd0;
        r.hold     = 1'b1;
        r.up       = 1'b1;
        if (taken) begin
            m_pc[d]    = ins[3:0];
            r.load_n   = 1'b0;
            r.load_val = ins[3:0];
        end else begin
            nxt = m_pc[d] + delta;
            if ((nxt < 0 || nxt > 15) && d == 1) begin
                m_fault[d] = 1'b1;
                m_halt[d]  = 1'b1;
            end else begin
                m_pc[d] = (nxt + 16) % 16;
                r.hold  = 1'b0;
                r.up    = (delta > 0);
            end
        end
        if (op == 15) m_halt[d] = 1'b1;
        r.halt_after  = m_halt[d];
        r.fault_after = m_fault[d];
    endfunction

    task automatic drive(input int d, input int n, input int zmode);
        int   done  = 0;
        int   cyc   = 0;
        int   fwait = 0;
        rec_t r;
        logic z;
        while (done < n) begin
            @(negedge clock);
            cyc++;
            start[d] = 1'b0;
            if (cyc > 10 * n + 40) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout dut%0d: actual=%0d instrs required=%0d", d, done, n);
                break;
            end
            if (m_halt[d]) begin
                if (halted[d]) begin
                    if (m_fault[d]) begin
                        if (fwait >= 4) break;
                        start[d] = 1'b1;
                        fwait++;
                    end else if ($urandom_range(0, 2) == 0) begin
                        start[d]  = 1'b1;
                        m_halt[d] = 1'b0;
                    end
                end
            end else if (!ir_valid[d] && !halted[d] && pc_reset_n[d]) begin
                z     = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 1);
                zf[d] = z;
                model_step(d, rom[m_pc[d]], z, r);
                push_rec(d, r);
                done++;
            end
        end
        start[d] = 1'b0;
    endtask

    task automatic monitor(input int d);
        rec_t r;
        forever begin
            @(negedge clock);
            if (mon_en && ir_valid[d]) begin
                if (q_size(d) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_exec dut%0d: actual pc=%0h ir=%0h required=no exec", d, cnt[d], ir[d]);
                end else begin
                    r = pop_rec(d);
                    chk("exec_pc", d, cnt[d], r.pc);
                    chk("exec_ir", d, ir[d], r.ir);
                    chk("exec_load_n", d, pc_load_n[d], r.load_n);
                    chk("exec_hold", d, pc_hold[d], r.hold);
                    chk("exec_up", d, pc_up[d], r.up);
                    if (!r.load_n) chk("exec_load_value", d, pc_load_value[d], r.load_val);
                    @(posedge clock);
                    #1;
                    chk("post_halted", d, halted[d], r.halt_after);
                    chk("post_fault", d, fault[d], r.fault_after);
                end
            end
        end
    endtask

    task automatic run_phase(input int n, input int zmode);
        reset = 1'b1;
        start = 2'b00;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            m_pc[d]    = 0;
            m_halt[d]  = 1'b0;
            m_fault[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
        mon_en = 1'b1;
        reset  = 1'b0;
        fork
            drive(0, n, zmode);
            drive(1, n, zmode);
        join
        repeat (2) @(negedge clock);
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("queue_drained", d, q_size(d), 0);
            chk("end_halted", d, halted[d], m_halt[d]);
            chk("end_fault", d, fault[d], m_fault[d]);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic rand_rom();
        int k;
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                4:       rom[i] = {4'h9, 4'($urandom_range(0, 15))};
                5:       rom[i] = {4'hA, 4'($urandom_range(0, 15))};
                6:       rom[i] = {4'hB, 4'($urandom_range(0, 15))};
                7:       rom[i] = {4'hC, 4'($urandom_range(0, 15))};
                8:       rom[i] = {4'hF, 4'($urandom_range(0, 15))};
                9:       rom[i] = {4'($urandom_range(13, 14)), 4'($urandom_range(0, 15))};
                default: rom[i] = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
            endcase
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        zf    = 2'b00;
        start = 2'b00;
        clear_rom();
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("rst_pc_reset_n", d, pc_reset_n[d], 1'b0);
            chk("rst_pc_load_n", d, pc_load_n[d], 1'b1);
            chk("rst_load_value", d, pc_load_value[d], 4'd0);
            chk("rst_pc_hold", d, pc_hold[d], 1'b1);
            chk("rst_pc_up", d, pc_up[d], 1'b1);
            chk("rst_ir", d, ir[d], 8'h00);
            chk("rst_ir_valid", d, ir_valid[d], 1'b0);
            chk("rst_halted", d, halted[d], 1'b0);
            chk("rst_fault", d, fault[d], 1'b0);
        end

        // NOP run through address 15: wrap on dut0, trapped fault on dut1.
        clear_rom();
        run_phase(20, 0);

        clear_rom(); rom[3] = 8'hA7;
        run_phase(6, 0);

        clear_rom(); rom[2] = 8'hB5;
        run_phase(4, 1);
        run_phase(4, 2);

        clear_rom(); rom[2] = 8'hC5;
        run_phase(4, 1);
        run_phase(4, 2);

        clear_rom(); rom[4] = 8'h90;
        run_phase(6, 0);

        clear_rom(); rom[0] = 8'h90;
        run_phase(4, 0);

        clear_rom(); rom[5] = 8'hF0;
        run_phase(8, 0);

        for (int it = 0; it < 6; it++) begin
            rand_rom();
            run_phase(40, 0);
        end

        // Reset asserted in the EXEC of a JMP must clear the counter, not load it.
        clear_rom(); rom[0] = 8'hA7;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("mid_fetch_pc", d, cnt[d], 4'd0);
            chk("mid_fetch_ir_valid", d, ir_valid[d], 1'b0);
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("mid_exec_ir_valid", d, ir_valid[d], 1'b1);
            chk("mid_exec_ir", d, ir[d], 8'hA7);
            chk("mid_exec_load_n", d, pc_load_n[d], 1'b0);
            chk("mid_exec_load_value", d, pc_load_value[d], 4'd7);
        end
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_load_n", d, pc_load_n[d], 1'b1);
            chk("mid_rst_reset_n", d, pc_reset_n[d], 1'b0);
            chk("mid_rst_load_value", d, pc_load_value[d], 4'd0);
            chk("mid_rst_ir", d, ir[d], 8'h00);
            chk("mid_rst_ir_valid", d, ir_valid[d], 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("after_rst_pc", d, cnt[d], 4'd0);
            chk("after_rst_clear", d, pc_reset_n[d], 1'b0);
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("refetch_pc", d, cnt[d], 4'd0);
            chk("refetch_reset_n", d, pc_reset_n[d], 1'b1);
            chk("refetch_ir_valid", d, ir_valid[d], 1'b0);
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("reexec_ir_valid", d, ir_valid[d], 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
